// File: rtl/fp_mult_round_pack.sv
// Output stage for the bfloat16 multiplier path: captures the 19-bit product (with guard/round/sticky),
// rounds it to bfloat16 in a two-register pipeline, and tracks sticky exception flags and a result count.
module fp_mult_round_pack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [18:0]      in_data,
  input  logic             rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  input  logic             clear_flags,
  output logic             flag_inexact,
  output logic             flag_overflow,
  output logic             flag_nan,
  output logic [CNT_W-1:0] result_count
);

  localparam int F_INX = 0;
  localparam int F_OVF = 1;
  localparam int F_NAN = 2;

  logic             s1_valid_q, s1_valid_d;
  logic [18:0]      s1_data_q, s1_data_d;
  logic             s1_rtz_q, s1_rtz_d;
  logic             s2_valid_q, s2_valid_d;
  logic [15:0]      s2_data_q, s2_data_d;
  logic [2:0]       s2_flags_q, s2_flags_d;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic s2_free, s1_adv, in_hs, out_hs;

  assign s2_free = !s2_valid_q || out_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_hs   = in_valid && in_ready;
  assign out_hs  = s2_valid_q && out_ready;

  // Rounding datapath operating on the S1 capture
  logic        sgn;
  logic [7:0]  exp_w;
  logic [9:0]  mant_w;
  logic        grd, rnd, stk, inc_w;
  logic [14:0] sum_w;
  logic [15:0] rnd_res;
  logic [2:0]  rnd_flags;

  assign sgn    = s1_data_q[18];
  assign exp_w  = s1_data_q[17:10];
  assign mant_w = s1_data_q[9:0];
  assign grd    = s1_data_q[2];
  assign rnd    = s1_data_q[1];
  assign stk    = s1_data_q[0];

  always_comb begin
    rnd_res   = 16'h0000;
    rnd_flags = 3'b000;
    inc_w     = 1'b0;
    sum_w     = 15'h0000;
    if (exp_w == 8'h00) begin
      rnd_res          = {sgn, 15'h0000};
      rnd_flags[F_INX] = |mant_w;
    end else if (exp_w == 8'hFF) begin
      if (mant_w == 10'h000) begin
        rnd_res = {sgn, 8'hFF, 7'h00};
      end else begin
        rnd_res          = 16'h7FC0;
        rnd_flags[F_NAN] = 1'b1;
      end
    end else begin
      // Fraction carry ripples into the exponent through the single 15-bit add.
      inc_w            = !s1_rtz_q && grd && (rnd || stk || s1_data_q[3]);
      sum_w            = {exp_w, s1_data_q[9:3]} + {14'h0000, inc_w};
      rnd_flags[F_INX] = grd || rnd || stk;
      if (sum_w[14:7] == 8'hFF) begin
        if (s1_rtz_q) begin
          rnd_res = {sgn, 8'hFE, 7'h7F};
        end else begin
          rnd_res          = {sgn, 8'hFF, 7'h00};
          rnd_flags[F_OVF] = 1'b1;
        end
      end else begin
        rnd_res = {sgn, sum_w};
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_rtz_d   = s1_rtz_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_flags_d = s2_flags_q;
    count_d    = count_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_hs) begin
      s1_data_d = in_data;
      s1_rtz_d  = rnd_mode;
    end
    // S2 only reloads when free, so a stalled output stays stable.
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_adv) begin
      s2_data_d  = rnd_res;
      s2_flags_d = rnd_flags;
    end
    if (out_hs) begin
      count_d = count_q + 1'b1;
    end
  end

  // A flag being set in the same cycle as clear_flags ends up set.
  for (genvar gi = 0; gi < 3; gi++) begin : g_flag
    assign flags_d[gi] = (flags_q[gi] && !clear_flags) || (out_hs && s2_flags_q[gi]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_rtz_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= 16'h0000;
      s2_flags_q <= 3'b000;
      flags_q    <= 3'b000;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_rtz_q   <= s1_rtz_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_flags_q <= s2_flags_d;
      flags_q    <= flags_d;
      count_q    <= count_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_data      = s2_data_q;
  assign flag_inexact  = flags_q[F_INX];
  assign flag_overflow = flags_q[F_OVF];
  assign flag_nan      = flags_q[F_NAN];
  assign result_count  = count_q;

endmodule

// File: tb/tb_fp_mult_round_pack.sv
// Bench for fp_mult_round_pack: directed rounding/special vectors, flag-clear collision,
// randomized traffic against an arithmetic reference model, backpressure and mid-stream reset.
module tb_fp_mult_round_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [18:0] in_data = '0;
  logic        rnd_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        clear_flags = 1'b0;
  logic        flag_inexact, flag_overflow, flag_nan;
  logic [15:0] result_count;

  int checks = 0;
  int errors = 0;

  fp_mult_round_pack #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clear_flags(clear_flags),
    .flag_inexact(flag_inexact), .flag_overflow(flag_overflow), .flag_nan(flag_nan),
    .result_count(result_count)
  );

  always #5 clk = ~clk;

  // Reference: returns {result[15:0], nan, overflow, inexact}
  function automatic logic [18:0] model(input logic [18:0] d, input logic rm);
    logic        sign;
    int          e, m, t, rem, mag;
    logic        up, inx, ovf, nan;
    logic [15:0] res;
    sign = d[18];
    e = int'(d[17:10]);
    m = int'(d[9:0]);
    inx = 0; ovf = 0; nan = 0; res = 16'h0;
    if (e == 0) begin
      res = {sign, 15'h0};
      inx = (m != 0);
    end else if (e == 255) begin
      if (m == 0) res = {sign, 8'hFF, 7'h00};
      else begin res = 16'h7FC0; nan = 1; end
    end else begin
      t = m / 8;
      rem = m % 8;
      up = (rm == 1'b0) && ((rem > 4) || (rem == 4 && (t % 2) == 1));
      mag = e * 128 + t + (up ? 1 : 0);
      inx = (rem != 0);
      if (mag >= 255 * 128) begin
        if (rm) mag = 254 * 128 + 127;
        else begin mag = 255 * 128; ovf = 1; end
      end
      res = {sign, mag[14:0]};
    end
    return {res, nan, ovf, inx};
  endfunction

  localparam int NV = 9;
  localparam logic [18:0] V_D   [NV] = '{19'h1FC0C, 19'h1FC04, 19'h1FC0C, 19'h3FBFC, 19'h3FBFC,
                                         19'h3FC01, 19'h7FC00, 19'h40005, 19'h43C00};
  localparam logic        V_RM  [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] V_RES [NV] = '{16'h3F82, 16'h3F80, 16'h3F81, 16'h7F80, 16'h7F7F,
                                         16'h7FC0, 16'hFF80, 16'h8000, 16'h8780};
  localparam logic [2:0]  V_FLG [NV] = '{3'b001, 3'b001, 3'b001, 3'b011, 3'b001,
                                         3'b100, 3'b000, 3'b001, 3'b000};

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; clear_flags = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic clear_pulse();
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
  endtask

  // Pushes one item into an idle pipe and returns the delivered word.
  task automatic run_one(input logic [18:0] d, input logic rm, output logic [15:0] res, output bit ok);
    bit got, acc;
    in_data = d; rnd_mode = rm; in_valid = 1'b1; out_ready = 1'b1;
    ok = 0; res = 16'h0;
    for (int c = 0; c < 20; c++) begin
      #1;
      got = out_valid;
      acc = in_valid && in_ready;
      if (got) res = out_data;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      if (got) begin ok = 1; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || result_count !== 16'h0 || in_ready !== 1'b1 ||
        {flag_nan, flag_overflow, flag_inexact} !== 3'b000) begin
      errors++;
      $display("FAIL reset: out_valid=%b out_data=%h count=%0d in_ready=%b flags=%b, required 0 0000 0 1 000",
               out_valid, out_data, result_count, in_ready, {flag_nan, flag_overflow, flag_inexact});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exact_latency();
    in_data = 19'h1FC00; rnd_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early: out_valid=%b required 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h3F80) begin
      errors++; $display("FAIL exact_one: out_valid=%b out_data=%h required 1 3f80", out_valid, out_data);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || result_count !== 16'd1 || {flag_nan, flag_overflow, flag_inexact} !== 3'b000) begin
      errors++;
      $display("FAIL exact_after: out_valid=%b count=%0d flags=%b required 0 1 000",
               out_valid, result_count, {flag_nan, flag_overflow, flag_inexact});
    end
  endtask

  task automatic test_directed_vectors();
    logic [15:0] res;
    bit ok;
    for (int i = 0; i < NV; i++) begin
      clear_pulse();
      run_one(V_D[i], V_RM[i], res, ok);
      checks++;
      if (!ok || res !== V_RES[i]) begin
        errors++;
        $display("FAIL vec%0d_data: in=%h rm=%b got=%h (delivered=%0d) required %h", i, V_D[i], V_RM[i], res, ok, V_RES[i]);
      end
      checks++;
      if ({flag_nan, flag_overflow, flag_inexact} !== V_FLG[i]) begin
        errors++;
        $display("FAIL vec%0d_flags: nan/ovf/inx=%b required %b", i, {flag_nan, flag_overflow, flag_inexact}, V_FLG[i]);
      end
    end
  endtask

  task automatic test_flag_clear_collision();
    logic [15:0] res;
    bit ok;
    run_one(19'h3FBFC, 1'b0, res, ok);   // leaves overflow and inexact set
    out_ready = 1'b0;
    in_data = 19'h3FC01; rnd_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 10 && out_valid !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1; clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    checks++;
    if ({flag_nan, flag_overflow, flag_inexact} !== 3'b100) begin
      errors++; $display("FAIL clear_collision: flags=%b required 100", {flag_nan, flag_overflow, flag_inexact});
    end
    clear_pulse();
    checks++;
    if ({flag_nan, flag_overflow, flag_inexact} !== 3'b000) begin
      errors++; $display("FAIL clear_alone: flags=%b required 000", {flag_nan, flag_overflow, flag_inexact});
    end
  endtask

  task automatic test_random();
    logic [18:0] exp_q[$];
    logic [18:0] exp_item, d;
    logic [2:0]  flags_exp;
    logic [15:0] held_data;
    bit          held, in_hs, out_hs, rm;
    int          cnt_exp, sel, bad;
    logic [7:0]  e;
    logic [9:0]  m;
    do_reset();
    flags_exp = 3'b000; cnt_exp = 0; held = 0; held_data = 16'h0; bad = 0;
    for (int cyc = 0; cyc < 330; cyc++) begin
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data) begin
          errors++; $display("FAIL stall_stable: out_valid=%b out_data=%h required 1 %h", out_valid, out_data, held_data);
        end
      end
      sel = $urandom_range(0, 3);
      e = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'hFE : 8'($urandom_range(1, 254));
      m = 10'($urandom);
      if ($urandom_range(0, 3) == 0) m = 10'h0;
      d = {1'($urandom), e, m};
      rm = 1'($urandom);
      if (cyc < 300) begin
        in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
        clear_flags = ($urandom_range(0, 7) == 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; clear_flags = 1'b0;
      end
      in_data = d; rnd_mode = rm;
      #1;
      checks++;
      if (in_ready !== (exp_q.size() < 2 || out_ready)) begin
        errors++; $display("FAIL in_ready: got %b required %b (occupancy %0d)", in_ready, (exp_q.size() < 2 || out_ready), exp_q.size());
      end
      in_hs = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      held = out_valid && !out_ready;
      held_data = out_data;
      flags_exp = clear_flags ? 3'b000 : flags_exp;
      if (out_hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra: unexpected output %h", out_data);
        end else begin
          exp_item = exp_q.pop_front();
          if (out_data !== exp_item[18:3]) begin
            errors++; $display("FAIL rand_data: got %h required %h", out_data, exp_item[18:3]);
          end
          flags_exp = flags_exp | exp_item[2:0];
          cnt_exp++;
        end
      end
      if (in_hs) exp_q.push_back(model(d, rm));
      @(posedge clk); #1;
      checks++;
      if ({flag_nan, flag_overflow, flag_inexact} !== flags_exp || result_count !== 16'(cnt_exp)) begin
        errors++;
        $display("FAIL rand_state: flags=%b count=%0d required %b %0d",
                 {flag_nan, flag_overflow, flag_inexact}, result_count, flags_exp, cnt_exp);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_drain: %0d items undelivered, required 0", exp_q.size());
    end
    clear_flags = 1'b0;
  endtask

  task automatic test_backpressure();
    int sent, recv, occ, saw_low;
    bit in_hs, out_hs;
    do_reset();
    sent = 0; recv = 0; occ = 0; saw_low = 0;
    for (int c = 0; c < 60 && recv < 10; c++) begin
      in_valid = (sent < 10);
      in_data = 19'h1FC00 + 19'(sent * 8);
      rnd_mode = 1'b0;
      out_ready = !(c >= 3 && c <= 7);
      #1;
      checks++;
      if (in_ready !== (occ < 2 || out_ready)) begin
        errors++; $display("FAIL bp_in_ready: cycle %0d got %b required %b", c, in_ready, (occ < 2 || out_ready));
      end
      if (!in_ready) saw_low++;
      in_hs = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (out_hs) begin
        checks++;
        if (out_data !== 16'(16'h3F80 + recv)) begin
          errors++; $display("FAIL bp_order: item %0d got %h required %h", recv, out_data, 16'(16'h3F80 + recv));
        end
        recv++;
      end
      if (in_hs) sent++;
      occ = occ + (in_hs ? 1 : 0) - (out_hs ? 1 : 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (recv != 10 || result_count !== 16'd10 || saw_low == 0) begin
      errors++;
      $display("FAIL bp_summary: received=%0d count=%0d in_ready_low_cycles=%0d required 10 10 >0", recv, result_count, saw_low);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 19'h3FC01; rnd_mode = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!in_ready) break;
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_fill: in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
    end
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || result_count !== 16'd0 || out_data !== 16'h0 || in_ready !== 1'b1 || flag_nan !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b count=%0d out_data=%h in_ready=%b nan=%b required 0 0 0000 1 0",
               out_valid, result_count, out_data, in_ready, flag_nan);
    end
    reset = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result_count !== 16'd0 || flag_nan !== 1'b0) begin
      errors++; $display("FAIL mid_after: out_valid=%b count=%0d nan=%b required 0 0 0", out_valid, result_count, flag_nan);
    end
  endtask

  initial begin
    test_reset();
    test_exact_latency();
    test_directed_vectors();
    test_flag_clear_collision();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
